// File: rtl/store_narrow_if.sv
// Store request and data-memory write bus shared by the store formatter and its environment.
// The slave modport is the store unit; the master modport is the requester plus memory model.
interface store_narrow_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        busy;
  logic        misalign_err;
  logic        timeout_err;
  logic [31:0] err_addr;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ack,
    output req_ready, mem_wen, mem_addr, mem_wdata, mem_be,
           busy, misalign_err, timeout_err, err_addr
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ack,
    input  req_ready, mem_wen, mem_addr, mem_wdata, mem_be,
           busy, misalign_err, timeout_err, err_addr
  );
endinterface

// File: rtl/store_narrow_unit.sv
// SB/SH/SW store formatter: narrows and lane-replicates register data, builds little-endian
// byte enables and holds a word-aligned write until mem_ack, flagging misalignment and timeouts.
module store_narrow_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  store_narrow_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              wen_q, wen_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mis_q, mis_d;
  logic              to_q, to_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              req_ready;
  logic              accept;
  logic              misaligned;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_be;

  // Ready also opens during the ack cycle so stores can stream back to back.
  assign req_ready = rst_n & ((state_q == IDLE) | ((state_q == WRITE) & bus.mem_ack));
  assign accept    = bus.req_valid & req_ready;

  always_comb begin
    misaligned = 1'b0;
    fmt_wdata  = bus.req_data;
    fmt_be     = 4'b1111;
    unique case (bus.req_size)
      SIZE_BYTE: begin
        fmt_wdata = {4{bus.req_data[7:0]}};
        fmt_be    = 4'b0001 << bus.req_addr[1:0];
      end
      SIZE_HALF: begin
        misaligned = bus.req_addr[0];
        fmt_wdata  = {2{bus.req_data[15:0]}};
        fmt_be     = 4'b0011 << bus.req_addr[1:0];
      end
      SIZE_WORD: misaligned = (bus.req_addr[1:0] != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a blocking default first, so no path through this block can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    mis_d      = 1'b0;
    to_d       = 1'b0;
    err_addr_d = err_addr_q;

    unique case (state_q)
      IDLE: ;
      WRITE: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          wen_d   = 1'b0;
          be_d    = 4'b0000;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          wen_d      = 1'b0;
          be_d       = 4'b0000;
          cnt_d      = '0;
          to_d       = 1'b1;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is only possible in IDLE or in the WRITE ack cycle, so it overrides the above.
    if (accept) begin
      cnt_d = '0;
      if (misaligned) begin
        state_d    = IDLE;
        wen_d      = 1'b0;
        be_d       = 4'b0000;
        mis_d      = 1'b1;
        err_addr_d = bus.req_addr;
      end else begin
        state_d = WRITE;
        wen_d   = 1'b1;
        addr_d  = {bus.req_addr[31:2], 2'b00};
        wdata_d = fmt_wdata;
        be_d    = fmt_be;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values of all others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.mem_wen      = wen_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_be       = be_q;
  assign bus.busy         = (state_q == WRITE);
  assign bus.misalign_err = mis_q;
  assign bus.timeout_err  = to_q;
  assign bus.err_addr     = err_addr_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: inputs change on the falling edge, a scoreboard checks every
// write beat against queued expectations, and each scenario task checks its own outcomes.
module tb_store_narrow_unit;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  store_narrow_if bus();

  store_narrow_unit #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Scoreboard: every mem_wen cycle must present the queue head; ack or timeout retires it.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.mem_wen) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write got addr=%h wdata=%h be=%b required no write",
                 bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end else if (bus.mem_addr !== sb[0].addr || bus.mem_wdata !== sb[0].wdata ||
                   bus.mem_be !== sb[0].be) begin
        failures++;
        $display("FAIL sb_beat got addr=%h wdata=%h be=%b required addr=%h wdata=%h be=%b",
                 bus.mem_addr, bus.mem_wdata, bus.mem_be, sb[0].addr, sb[0].wdata, sb[0].be);
      end
      if (bus.mem_ack && sb.size() > 0) void'(sb.pop_front());
    end
    if (rst_n && bus.timeout_err && sb.size() > 0) void'(sb.pop_front());
  end

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input int ack_at, output int wen_n, output int mis_n,
                           output int to_n);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wen_n = 0;
    mis_n = 0;
    to_n  = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_wen === 1'b1) wen_n++;
      if (bus.misalign_err === 1'b1) mis_n++;
      if (bus.timeout_err === 1'b1) to_n++;
      bus.mem_ack = (ack_at != 0) && (bus.mem_wen === 1'b1) && (wen_n == ack_at);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.mem_wen !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got ready=%b wen=%b busy=%b required 0 0 0",
               bus.req_ready, bus.mem_wen, bus.busy);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0 ||
        bus.err_addr !== 32'h0 || bus.misalign_err !== 1'b0 || bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got addr=%h wdata=%h be=%b err_addr=%h mis=%b to=%b required all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.err_addr,
               bus.misalign_err, bus.timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_idle got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_sb;
    int w, m, t;
    sb.push_back('{32'h1000_0000, 32'hDDDD_DDDD, 4'b1000});
    run_store(32'h1000_0003, 32'hAABB_CCDD, 2'b00, 3, w, m, t);
    checks++;
    if (w != 3 || m != 0 || t != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL sb_store got wen_cycles=%0d mis=%0d to=%0d busy=%b required 3 0 0 0",
               w, m, t, bus.busy);
    end
  endtask

  task automatic test_sh;
    int w, m, t;
    sb.push_back('{32'h0000_2000, 32'h1234_1234, 4'b1100});
    run_store(32'h0000_2002, 32'h0000_1234, 2'b01, 1, w, m, t);
    checks++;
    if (w != 1 || m != 0 || t != 0) begin
      failures++;
      $display("FAIL sh_store got wen_cycles=%0d mis=%0d to=%0d required 1 0 0", w, m, t);
    end
  endtask

  task automatic test_misalign;
    int w, m, t;
    run_store(32'h0000_0006, 32'h1111_2222, 2'b10, 1, w, m, t);
    checks++;
    if (w != 0 || m != 1 || t != 0 || bus.err_addr !== 32'h0000_0006) begin
      failures++;
      $display("FAIL misalign_sw got wen=%0d mis=%0d to=%0d err_addr=%h required 0 1 0 00000006",
               w, m, t, bus.err_addr);
    end
    run_store(32'h0000_0000, 32'h3333_4444, 2'b11, 1, w, m, t);
    checks++;
    if (w != 0 || m != 1 || bus.err_addr !== 32'h0000_0000) begin
      failures++;
      $display("FAIL misalign_size11 got wen=%0d mis=%0d err_addr=%h required 0 1 00000000",
               w, m, bus.err_addr);
    end
    run_store(32'h0000_0031, 32'h5555_6666, 2'b01, 1, w, m, t);
    checks++;
    if (w != 0 || m != 1 || bus.err_addr !== 32'h0000_0031) begin
      failures++;
      $display("FAIL misalign_sh got wen=%0d mis=%0d err_addr=%h required 0 1 00000031",
               w, m, bus.err_addr);
    end
  endtask

  task automatic test_back_to_back;
    sb.push_back('{32'h0000_0010, 32'h0BAD_F00D, 4'b1111});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    bus.req_data  = 32'h0BAD_F00D;
    bus.req_size  = 2'b10;
    @(negedge clk);
    sb.push_back('{32'h0000_0014, 32'h7F7F_7F7F, 4'b0010});
    bus.mem_ack  = 1'b1;
    bus.req_addr = 32'h0000_0015;
    bus.req_data = 32'h0000_007F;
    bus.req_size = 2'b00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_wen !== 1'b1 || bus.busy !== 1'b1 || bus.mem_addr !== 32'h0000_0014) begin
      failures++;
      $display("FAIL b2b_second_beat got wen=%b busy=%b addr=%h required 1 1 00000014",
               bus.mem_wen, bus.busy, bus.mem_addr);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_wen !== 1'b0 || bus.mem_be !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done got wen=%b be=%b busy=%b required 0 0000 0",
               bus.mem_wen, bus.mem_be, bus.busy);
    end
  endtask

  task automatic test_misalign_in_ack;
    sb.push_back('{32'h0000_0020, 32'h2020_2020, 4'b1111});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    bus.req_data  = 32'h2020_2020;
    bus.req_size  = 2'b10;
    @(negedge clk);
    bus.mem_ack  = 1'b1;
    bus.req_addr = 32'h0000_0021;
    bus.req_size = 2'b01;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
    checks++;
    if (bus.misalign_err !== 1'b1 || bus.mem_wen !== 1'b0 || bus.busy !== 1'b0 ||
        bus.err_addr !== 32'h0000_0021) begin
      failures++;
      $display("FAIL ack_misalign got mis=%b wen=%b busy=%b err_addr=%h required 1 0 0 00000021",
               bus.misalign_err, bus.mem_wen, bus.busy, bus.err_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL ack_misalign_pulse got %b required 0", bus.misalign_err);
    end
  endtask

  task automatic test_timeout;
    int w, m, t;
    sb.push_back('{32'h0000_0040, 32'hCAFE_0040, 4'b1111});
    run_store(32'h0000_0040, 32'hCAFE_0040, 2'b10, 0, w, m, t);
    checks++;
    if (w != 4 || t != 1 || m != 0 || bus.err_addr !== 32'h0000_0040) begin
      failures++;
      $display("FAIL timeout got wen=%0d to=%0d mis=%0d err_addr=%h required 4 1 0 00000040",
               w, t, m, bus.err_addr);
    end
    sb.push_back('{32'h0000_0040, 32'hBEEF_0040, 4'b1111});
    run_store(32'h0000_0040, 32'hBEEF_0040, 2'b10, 4, w, m, t);
    checks++;
    if (w != 4 || t != 0) begin
      failures++;
      $display("FAIL timeout_ack_wins got wen=%0d to=%0d required 4 0", w, t);
    end
  endtask

  task automatic test_idle_ack;
    int bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b1;
      if (bus.mem_wen !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) bad++;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    if (bus.mem_wen !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_ack got %0d disturbed cycles required 0", bad);
    end
  endtask

  task automatic test_reset_mid_write;
    int bad = 0;
    sb.push_back('{32'h0000_0080, 32'h8080_8080, 4'b1111});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0080;
    bus.req_data  = 32'h8080_8080;
    bus.req_size  = 2'b10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_wen !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre got wen=%b required 1", bus.mem_wen);
    end
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (bus.mem_wen !== 1'b0 || bus.req_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async got wen=%b ready=%b busy=%b required 0 0 0",
               bus.mem_wen, bus.req_ready, bus.busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_release got ready=%b required 1", bus.req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_wen !== 1'b0 || bus.misalign_err !== 1'b0 || bus.timeout_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got %0d noisy cycles required 0", bad);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    bus.mem_ack   = 1'b0;
    test_reset;
    test_sb;
    test_sh;
    test_misalign;
    test_back_to_back;
    test_misalign_in_ack;
    test_timeout;
    test_idle_ack;
    test_reset_mid_write;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained got %0d pending beats required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
Store-side data formatter and memory write sequencer for the MIPS datapath. It narrows 32-bit register data to byte, halfword or word stores (SB/SH/SW) and replicates the data across byte lanes. It generates little-endian byte enables and drives a word-aligned write handshake to data memory. It is the write-direction counterpart of the immediate/load-data extension path, and flags misaligned stores and memory timeouts.

Parameters:
TIMEOUT, 255, cycles in WRITE without mem_ack before aborting (1..65535)
CNT_W, 16, width of the timeout counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  store request valid
req_ready  output  1  unit can accept a request this cycle
req_addr  input  32  byte address of the store
req_data  input  32  rt register value; low bits are used for SB/SH
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
mem_wen  output  1  memory write request, held until ack or timeout
mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables; bit i enables byte lane i (bits 8i+7:8i)
mem_ack  input  1  memory accepted the write this cycle
busy  output  1  high in WRITE state
misalign_err  output  1  one-cycle pulse: misaligned or reserved-size request
timeout_err  output  1  one-cycle pulse: write aborted after TIMEOUT cycles
err_addr  output  32  req_addr of the most recent errored request

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - mem_wen, mem_addr, mem_wdata, mem_be, misalign_err, timeout_err, err_addr and the counter clear to 0.
  - req_ready = 0 while rst_n is low. In IDLE after reset, req_ready = 1.
  - Reset mid-WRITE drops mem_wen immediately. The pending store is discarded with no error pulse.
- States: IDLE, WRITE.
- req_ready = rst_n & ((state==IDLE) | (state==WRITE & mem_ack)).
- Acceptance is on req_valid & req_ready at a rising edge.
- Alignment check at acceptance. A request is misaligned when any of these holds:
  - size 01 and addr[0]=1
  - size 10 and addr[1:0]!=0
  - size 11
- Misaligned accept:
  - misalign_err pulses high the next cycle, for exactly one cycle.
  - err_addr <= req_addr.
  - No memory write is issued. State goes to IDLE, or stays IDLE.
- Aligned accept: the following are registered and state goes to WRITE. mem_wen is high on the cycle after acceptance (latency 1).
  - mem_addr = {addr[31:2],2'b00}
  - byte: mem_wdata = {4{data[7:0]}}, mem_be = 4'b0001 << addr[1:0]
  - half: mem_wdata = {2{data[15:0]}}, mem_be = 4'b0011 << addr[1:0]; addr[1] selects the lane pair
  - word: mem_wdata = data, mem_be = 4'b1111
- WRITE state:
  - mem_wen, mem_addr, mem_wdata and mem_be stay stable until mem_ack.
  - Counter increments each WRITE cycle without ack.
- mem_ack in WRITE:
  - The write completes and the counter clears.
  - If a new request is accepted in the same cycle, its outputs load and state stays WRITE, giving back-to-back stores with mem_wen continuously high.
  - Otherwise state goes to IDLE, and mem_wen and mem_be clear next cycle.
- Timeout: the counter reaching TIMEOUT-1 with no ack causes, next cycle:
  - timeout_err pulses for one cycle
  - err_addr <= mem_addr
  - mem_wen and mem_be clear and state goes to IDLE
  - mem_ack in that same cycle wins: normal completion, no timeout_err.
- mem_ack in IDLE is ignored.
- A misaligned request accepted in the ack cycle raises misalign_err and returns the unit to IDLE.
- busy = (state==WRITE).

Test Plan:
- SB addr 0x1000_0003, data 0xAABB_CCDD, ack after 2 cycles -> mem_addr 0x1000_0000, wdata 0xDDDD_DDDD, be 4'b1000, mem_wen high for 3 cycles, then IDLE.
- SH addr 0x2002, data 0x0000_1234, immediate ack -> wdata 0x1234_1234, be 4'b1100, one-cycle mem_wen.
- SW addr 0x0000_0006 -> misalign_err one-cycle pulse, err_addr 0x0000_0006, mem_wen never asserts; size 11 at addr 0 also errors.
- Back-to-back SW 0x10 then SB 0x15 (data 0x7F) with second req presented during first ack -> mem_wen stays high; second beat shows addr 0x14, wdata 0x7F7F_7F7F, be 4'b0010.
- TIMEOUT=4, SW 0x40, no ack -> mem_wen high 4 cycles, timeout_err pulse, err_addr 0x40; repeat with ack on 4th cycle -> no timeout_err.
- Assert rst_n low during WRITE -> mem_wen drops asynchronously, req_ready 0 until release, then 1 in IDLE; no error pulses.
